// File: rtl/sirv_bootrom_icb.sv
// Boot ROM on an ICB-style bus: the lookup happens at command accept and the
// result goes into a 2-entry response FIFO, so read data appears the next cycle.
module sirv_bootrom_icb #(
  parameter int          AW        = 12,
  parameter int          DW        = 32,
  parameter logic [31:0] JUMP_ADDR = 32'h8000_0000,
  parameter logic [31:0] XIP_ADDR  = 32'h2040_0000,
  parameter logic [31:0] CFG_WORD  = 32'h0000_6661
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_mode,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [AW-1:0] icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [DW-1:0] icb_cmd_wdata,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [DW-1:0] icb_rsp_rdata,
  output logic          icb_rsp_err,
  output logic          mode_o
);

  localparam int WW = AW - 2;

  // Handshake: a command transfers on a cycle with icb_cmd_valid & icb_cmd_ready,
  // a response on a cycle with icb_rsp_valid & icb_rsp_ready; a raised valid
  // holds its payload until that transfer cycle.

  logic          mode_q;
  logic          lat_done_q;
  logic [1:0]    count_q, count_d;
  logic          wptr_q, rptr_q;
  logic [DW-1:0] data_q [2];
  logic          err_q  [2];

  logic          push, pop;
  logic [WW-1:0] widx;
  logic [31:0]   rom_word;
  logic [DW-1:0] lk_data;
  logic          lk_err;
  logic          unused_wdata;

  assign unused_wdata  = ^icb_cmd_wdata;
  assign widx          = icb_cmd_addr[AW-1:2];

  // Ready never looks at icb_rsp_ready, keeping the two channels decoupled.
  assign icb_cmd_ready = lat_done_q & (count_q != 2'd2);
  assign icb_rsp_valid = (count_q != 2'd0);
  assign push          = icb_cmd_valid & icb_cmd_ready;
  assign pop           = icb_rsp_valid & icb_rsp_ready;
  assign icb_rsp_rdata = data_q[rptr_q];
  assign icb_rsp_err   = err_q[rptr_q];
  assign mode_o        = mode_q;

  always_comb begin
    rom_word = 32'h0;
    if (!mode_q) begin
      case (widx)
        WW'(0):  rom_word = {JUMP_ADDR[31:12], 12'h2b7};
        WW'(1):  rom_word = 32'h0002_8067;
        default: rom_word = 32'h0;
      endcase
    end else begin
      case (widx)
        WW'(0):  rom_word = 32'h0100_006f;
        WW'(1):  rom_word = 32'h0000_0013;
        WW'(2):  rom_word = 32'h0000_0013;
        WW'(3):  rom_word = CFG_WORD;
        WW'(4):  rom_word = {XIP_ADDR[31:12], 12'h2b7};
        WW'(5):  rom_word = 32'h0002_8067;
        default: rom_word = 32'h0;
      endcase
    end
  end

  always_comb begin
    lk_data = '0;
    lk_err  = 1'b0;
    if (!icb_cmd_read || (icb_cmd_addr[1:0] != 2'b00)) begin
      lk_err = 1'b1;
    end else begin
      lk_data = DW'(rom_word);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // The mode is captured on the first clock after reset and frozen afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      lat_done_q <= 1'b0;
    end else if (!lat_done_q) begin
      mode_q     <= boot_mode;
      lat_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        data_q[wptr_q] <= lk_data;
        err_q[wptr_q]  <= lk_err;
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
    end
  end

endmodule

// File: tb/tb_sirv_bootrom_icb.sv
// Directed bench for sirv_bootrom_icb: a queue-based response model checked
// every cycle, plus literal expectations on the returned words.
module tb_sirv_bootrom_icb;

  localparam logic [31:0] JUMP = 32'h8000_0000;
  localparam logic [31:0] XIP  = 32'h2040_0000;
  localparam logic [31:0] CFG  = 32'h0000_6661;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_mode = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_addr = '0;
  logic        cmd_read = 1'b1;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mode_o;

  int compared = 0;
  int mismatched = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  bit          m_known = 1'b0;
  bit          m_mode = 1'b0;
  logic [31:0] rom0 [1024];
  logic [31:0] rom1 [1024];

  sirv_bootrom_icb #(
    .AW(12), .DW(32), .JUMP_ADDR(JUMP), .XIP_ADDR(XIP), .CFG_WORD(CFG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready),
    .icb_cmd_addr(cmd_addr), .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata),
    .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready),
    .icb_rsp_rdata(rsp_rdata), .icb_rsp_err(rsp_err), .mode_o(mode_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom0[i] = 32'h0;
      rom1[i] = 32'h0;
    end
    rom0[0] = (JUMP & 32'hFFFF_F000) | 32'h2b7;
    rom0[1] = 32'h0002_8067;
    rom1[0] = 32'h0100_006f;
    rom1[1] = 32'h13;
    rom1[2] = 32'h13;
    rom1[3] = CFG;
    rom1[4] = (XIP & 32'hFFFF_F000) | 32'h2b7;
    rom1[5] = 32'h0002_8067;
  end

  function automatic logic [32:0] model_rsp(bit md, logic [11:0] a, bit rd);
    if (!rd || (a % 4) != 0) return {32'h0, 1'b1};
    return {(md ? rom1[a / 4] : rom0[a / 4]), 1'b0};
  endfunction

  function automatic bit m_ready();
    return m_known && (exp_q.size() < 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_p
    bit acc, pp;
    if (!rst_n) begin
      exp_q.delete();
      m_known = 1'b0;
      m_mode  = 1'b0;
    end else begin
      acc = cmd_valid && m_ready();
      pp  = (exp_q.size() != 0) && rsp_ready;
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(model_rsp(m_mode, cmd_addr, cmd_read));
      if (!m_known) begin
        m_known = 1'b1;
        m_mode  = boot_mode;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rsp_valid", rsp_valid, exp_q.size() != 0);
    chk("cmd_ready", cmd_ready, m_ready());
    chk("mode_o", mode_o, m_mode);
    if (exp_q.size() != 0) begin
      chk("rsp_payload", {rsp_rdata, rsp_err}, exp_q[0]);
      if (rsp_ready) got_q.push_back({rsp_rdata, rsp_err});
    end
  end

  task automatic expect_got(int idx, logic [32:0] v);
    if (idx >= got_q.size()) chk("got_missing", idx, got_q.size());
    else chk("got_word", got_q[idx], v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(bit md);
    @(posedge clk); #1;
    rst_n = 1'b0; boot_mode = md; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete();
    @(negedge clk);
    chk("ready_first_cycle", cmd_ready, 0);
    @(negedge clk);
    chk("mode_latched", mode_o, md);
    chk("ready_after_latch", cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(logic [11:0] a, bit rd);
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd;
    cmd_wdata = $urandom_range(0, 32'hFFFF);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_ready()) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    chk("issue_timeout", 1, 0);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] m1_words [11];

  initial begin
    m1_words = '{32'h0100_006f, 32'h13, 32'h13, 32'h6661, 32'h2040_02b7,
                 32'h0002_8067, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_mode_o", mode_o, 0);
    chk("reset_cmd_ready", cmd_ready, 0);

    // mode 0, back-to-back reads
    do_reset(1'b0);
    rsp_ready = 1'b1;
    issue(12'h000, 1'b1);
    issue(12'h004, 1'b1);
    issue(12'h008, 1'b1);
    drain();
    chk("m0_count", got_q.size(), 3);
    expect_got(0, {32'h8000_02b7, 1'b0});
    expect_got(1, {32'h0002_8067, 1'b0});
    expect_got(2, {32'h0000_0000, 1'b0});

    // back-pressure: two accepted, third stalls until the first pop
    got_q.delete();
    rsp_ready = 1'b0;
    issue(12'h000, 1'b1);
    issue(12'h000, 1'b1);
    cmd_valid = 1'b1; cmd_addr = 12'h000; cmd_read = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready_low", cmd_ready, 0);
      chk("full_hold_data", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'h8000_02b7, 1'b0});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("full_before_pop", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_pop", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drain();
    chk("bp_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) expect_got(i, {32'h8000_02b7, 1'b0});

    // error responses
    got_q.delete();
    issue(12'h004, 1'b0);
    issue(12'h002, 1'b1);
    issue(12'h004, 1'b1);
    drain();
    expect_got(0, {32'h0, 1'b1});
    expect_got(1, {32'h0, 1'b1});
    expect_got(2, {32'h0002_8067, 1'b0});

    // mode frozen after latch, then reset with pending responses
    got_q.delete();
    boot_mode = 1'b1;
    issue(12'h000, 1'b1);
    drain();
    chk("mode_frozen", mode_o, 0);
    expect_got(0, {32'h8000_02b7, 1'b0});
    rsp_ready = 1'b0;
    issue(12'h000, 1'b1);
    issue(12'h004, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_flush_valid", rsp_valid, 0);
    chk("async_flush_ready", cmd_ready, 0);
    do_reset(1'b1);

    // mode 1 contents
    rsp_ready = 1'b1;
    for (int w = 0; w < 7; w++) issue(12'(w * 4), 1'b1);
    drain();
    chk("m1_count", got_q.size(), 7);
    for (int w = 0; w < 7; w++) expect_got(w, {m1_words[w], 1'b0});

    // simultaneous push/pop with one entry held in the buffer
    got_q.delete();
    issue(12'h000, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      cmd_valid = 1'b1; cmd_addr = 12'(i * 4); cmd_read = 1'b1;
      @(negedge clk);
      chk("pp_ready", cmd_ready, 1);
      chk("pp_valid", rsp_valid, 1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    drain();
    chk("pp_count", got_q.size(), 11);
    for (int i = 0; i < 11; i++) expect_got(i, {m1_words[i], 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
